// File: rtl/arc4_core_param.sv
// arc4_core_param: ARC4 decrypt engine with a parametrised key length.
//
// Runs the full ARC4 flow against external memories:
//   INIT  - s[i] = i for i = 0..255
//   KSA   - key scheduling with a KEY_BYTES-long key, read MSB-first
//   LEN   - reads the length byte ct[0] and copies it to pt[0]
//   PRGA  - decrypts ct[1..L] into pt[1..L]
// With CHECK_PRINTABLE = 1 the run stops on the first plaintext byte
// outside [PRINT_LO, PRINT_HI]. That byte is still written, and valid
// reports 0. This lets a key search abandon a wrong key early.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en / rdy            start request (taken only while rdy = 1) / engine idle
//   key                 key, byte 0 = key[8*KEY_BYTES-1 -: 8]
//   valid               result of the last run (1 = every byte printable)
//   s_addr, s_rddata,
//   s_wrdata, s_wren    256x8 S memory port
//   ct_addr, ct_rddata  ciphertext memory read port
//   pt_addr, pt_wrdata,
//   pt_wren             plaintext memory write port
//
// All memories are synchronous with one cycle of read latency. Every output
// is registered, so an address issued by a state is presented to the memory
// on the next cycle. The read data is sampled two states later; the *_WT_*
// states cover that gap.
module arc4_core_param #(
    parameter int         KEY_BYTES       = 3,
    parameter bit         CHECK_PRINTABLE = 1'b1,
    parameter logic [7:0] PRINT_LO        = 8'h20,
    parameter logic [7:0] PRINT_HI        = 8'h7E
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   valid,
    output logic [7:0]             s_addr,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    output logic [7:0]             ct_addr,
    input  logic [7:0]             ct_rddata,
    output logic [7:0]             pt_addr,
    output logic [7:0]             pt_wrdata,
    output logic                   pt_wren
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [4:0] {
        IDLE,
        INIT,
        KSA_RD_I,  KSA_WT_I,  KSA_RD_J,  KSA_WT_J,  KSA_WR_I,  KSA_WR_J,
        LEN_RD,    LEN_WT,    LEN_CAP,
        PRGA_RD_I, PRGA_WT_I, PRGA_RD_J, PRGA_WT_J, PRGA_WR_I, PRGA_WR_J,
        PRGA_RD_P, PRGA_WT_P, PRGA_OUT,
        DONE
    } state_t;

    state_t                 state;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]             i, j, k, len;
    logic [7:0]             si, sj, ct_byte;
    logic [KW-1:0]          kidx;     // i mod KEY_BYTES, kept as a wrapping counter

    logic [7:0] key_byte;
    logic [7:0] j_ksa, j_prga, pt_byte;
    logic       bad_byte;

    // Select key byte kidx (MSB-first) without a variable-width part-select.
    always_comb begin
        key_byte = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx == KW'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
        end
    end

    always_comb begin
        j_ksa    = j + s_rddata + key_byte;
        j_prga   = j + s_rddata;
        pt_byte  = s_rddata ^ ct_byte;
        bad_byte = CHECK_PRINTABLE && ((pt_byte < PRINT_LO) || (pt_byte > PRINT_HI));
    end

    // NOTE: every register below is assigned with <=, so each state reads the
    // values from before the edge (e.g. KSA_WR_J writes s[j] using the j that
    // was computed in KSA_RD_J), independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            valid     <= 1'b0;
            key_q     <= '0;
            i         <= 8'h00;
            j         <= 8'h00;
            k         <= 8'h00;
            len       <= 8'h00;
            si        <= 8'h00;
            sj        <= 8'h00;
            ct_byte   <= 8'h00;
            kidx      <= '0;
            s_addr    <= 8'h00;
            s_wrdata  <= 8'h00;
            s_wren    <= 1'b0;
            ct_addr   <= 8'h00;
            pt_addr   <= 8'h00;
            pt_wrdata <= 8'h00;
            pt_wren   <= 1'b0;
        end else begin
            unique case (state)
                // DONE already shows rdy = 1, so it accepts a start as IDLE does.
                IDLE, DONE: begin
                    s_wren  <= 1'b0;
                    pt_wren <= 1'b0;
                    state   <= IDLE;
                    if (en) begin
                        key_q <= key;
                        valid <= 1'b0;
                        rdy   <= 1'b0;
                        i     <= 8'h00;
                        j     <= 8'h00;
                        kidx  <= '0;
                        state <= INIT;
                    end
                end

                INIT: begin
                    s_addr   <= i;
                    s_wrdata <= i;
                    s_wren   <= 1'b1;
                    i        <= i + 8'd1;            // wraps back to 0 for KSA
                    if (i == 8'hFF) state <= KSA_RD_I;
                end

                KSA_RD_I: begin
                    s_wren <= 1'b0;
                    s_addr <= i;
                    state  <= KSA_WT_I;
                end
                KSA_WT_I: state <= KSA_RD_J;
                KSA_RD_J: begin
                    si     <= s_rddata;
                    j      <= j_ksa;
                    s_addr <= j_ksa;
                    state  <= KSA_WT_J;
                end
                KSA_WT_J: state <= KSA_WR_I;
                KSA_WR_I: begin
                    s_addr   <= i;
                    s_wrdata <= s_rddata;            // old s[j]
                    s_wren   <= 1'b1;
                    state    <= KSA_WR_J;
                end
                // When i == j this second write restores old s[i], so the
                // swap degenerates to a no-op as it should.
                KSA_WR_J: begin
                    s_addr   <= j;
                    s_wrdata <= si;
                    s_wren   <= 1'b1;
                    i        <= i + 8'd1;
                    kidx     <= (kidx == KW'(KEY_BYTES - 1)) ? '0 : kidx + KW'(1);
                    state    <= (i == 8'hFF) ? LEN_RD : KSA_RD_I;
                end

                LEN_RD: begin
                    s_wren  <= 1'b0;
                    ct_addr <= 8'h00;
                    state   <= LEN_WT;
                end
                LEN_WT: state <= LEN_CAP;
                LEN_CAP: begin
                    len       <= ct_rddata;
                    pt_addr   <= 8'h00;
                    pt_wrdata <= ct_rddata;
                    pt_wren   <= 1'b1;
                    i         <= 8'h00;
                    j         <= 8'h00;
                    k         <= 8'h01;
                    if (ct_rddata == 8'h00) begin
                        valid <= 1'b1;
                        rdy   <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= PRGA_RD_I;
                    end
                end

                PRGA_RD_I: begin
                    pt_wren <= 1'b0;
                    s_wren  <= 1'b0;
                    i       <= i + 8'd1;
                    s_addr  <= i + 8'd1;
                    ct_addr <= k;                    // ct[k] is fetched alongside s[i]
                    state   <= PRGA_WT_I;
                end
                PRGA_WT_I: state <= PRGA_RD_J;
                PRGA_RD_J: begin
                    si      <= s_rddata;
                    ct_byte <= ct_rddata;
                    j       <= j_prga;
                    s_addr  <= j_prga;
                    state   <= PRGA_WT_J;
                end
                PRGA_WT_J: state <= PRGA_WR_I;
                PRGA_WR_I: begin
                    sj       <= s_rddata;
                    s_addr   <= i;
                    s_wrdata <= s_rddata;
                    s_wren   <= 1'b1;
                    state    <= PRGA_WR_J;
                end
                PRGA_WR_J: begin
                    s_addr   <= j;
                    s_wrdata <= si;
                    s_wren   <= 1'b1;
                    state    <= PRGA_RD_P;
                end
                // The swap leaves s[i] + s[j] unchanged, so the captured
                // pre-swap values address the pad directly.
                PRGA_RD_P: begin
                    s_wren <= 1'b0;
                    s_addr <= si + sj;
                    state  <= PRGA_WT_P;
                end
                PRGA_WT_P: state <= PRGA_OUT;
                PRGA_OUT: begin
                    pt_addr   <= k;
                    pt_wrdata <= pt_byte;
                    pt_wren   <= 1'b1;
                    if (bad_byte) begin
                        valid <= 1'b0;
                        rdy   <= 1'b1;
                        state <= DONE;
                    end else if (k == len) begin
                        valid <= 1'b1;
                        rdy   <= 1'b1;
                        state <= DONE;
                    end else begin
                        k     <= k + 8'd1;
                        state <= PRGA_RD_I;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_core_param.sv
// Bench for arc4_core_param. Three instances share clk/rst_n:
//   dut 0: KEY_BYTES=3, printable check on
//   dut 1: KEY_BYTES=4, printable check on
//   dut 2: KEY_BYTES=3, printable check off
// Stimulus pushes expected plaintext writes and completion flags into
// per-instance queues; a negedge monitor pops and compares them.
module tb_arc4_core_param;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   en_v = 3'b000;
    logic [2:0]   rdy_v, valid_v, s_wren_v, pt_wren_v;
    logic [127:0] key_v [3];
    logic [7:0]   s_addr_v [3];
    logic [7:0]   s_wd_v [3];
    logic [7:0]   ct_addr_v [3];
    logic [7:0]   pt_addr_v [3];
    logic [7:0]   pt_wd_v [3];
    logic [7:0]   ct_mem [3][256];

    wr_t exp_q [3][$];
    bit  exp_valid_q [3][$];
    int  wr_cnt [3]   = '{0, 0, 0};
    int  rise_cnt [3] = '{0, 0, 0};
    bit  prev_rdy [3] = '{1'b1, 1'b1, 1'b1};
    int  n_vec = 0;
    int  n_err = 0;
    int  last_writes;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KB = (g == 1) ? 4 : 3;
        localparam bit CH = (g == 2) ? 1'b0 : 1'b1;
        logic [7:0] s_mem [256];
        logic [7:0] s_rd, ct_rd;

        arc4_core_param #(
            .KEY_BYTES(KB), .CHECK_PRINTABLE(CH), .PRINT_LO(8'h20), .PRINT_HI(8'h7E)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .en(en_v[g]), .rdy(rdy_v[g]),
            .key(key_v[g][8*KB-1:0]), .valid(valid_v[g]),
            .s_addr(s_addr_v[g]), .s_rddata(s_rd), .s_wrdata(s_wd_v[g]), .s_wren(s_wren_v[g]),
            .ct_addr(ct_addr_v[g]), .ct_rddata(ct_rd),
            .pt_addr(pt_addr_v[g]), .pt_wrdata(pt_wd_v[g]), .pt_wren(pt_wren_v[g])
        );

        always @(posedge clk) begin
            if (s_wren_v[g]) s_mem[s_addr_v[g]] <= s_wd_v[g];
            s_rd  <= s_mem[s_addr_v[g]];
            ct_rd <= ct_mem[g][ct_addr_v[g]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst_n) begin
                if (pt_wren_v[g]) begin
                    wr_cnt[g]++;
                    if (exp_q[g].size() == 0)
                        check($sformatf("pt_write_unexpected[%0d]", g), 1, 0);
                    else
                        check($sformatf("pt_write[%0d]", g),
                              {pt_addr_v[g], pt_wd_v[g]}, exp_q[g].pop_front());
                end
                if (rdy_v[g] && !prev_rdy[g]) begin
                    rise_cnt[g]++;
                    if (exp_valid_q[g].size() == 0)
                        check($sformatf("rdy_rise_unexpected[%0d]", g), 1, 0);
                    else
                        check($sformatf("valid_at_done[%0d]", g),
                              valid_v[g], exp_valid_q[g].pop_front());
                end
            end
            prev_rdy[g] = rdy_v[g];
        end
    end

    task automatic load_ct(input int g, input byte_q_t v);
        for (int n = 0; n < v.size(); n++) ct_mem[g][n] = v[n];
    endtask

    task automatic push_exp(input int g, input byte_q_t v, input bit val);
        for (int n = 0; n < v.size(); n++) exp_q[g].push_back({n[7:0], v[n]});
        exp_valid_q[g].push_back(val);
    endtask

    // Plain software ARC4, used where no hand-derived answer exists (wrong key).
    task automatic rc4_push(input int g, input logic [127:0] kk, input int nk, input bit chk);
        logic [7:0] s [256];
        logic [7:0] t, kb, len, p;
        int ii, jj;
        bit ok;
        for (int n = 0; n < 256; n++) s[n] = n[7:0];
        jj = 0;
        for (int n = 0; n < 256; n++) begin
            kb = kk[8*(nk-1-(n % nk)) +: 8];
            jj = (jj + int'(s[n]) + int'(kb)) % 256;
            t = s[n]; s[n] = s[jj]; s[jj] = t;
        end
        len = ct_mem[g][0];
        exp_q[g].push_back({8'h00, len});
        ii = 0; jj = 0; ok = 1'b1;
        for (int n = 1; n <= int'(len); n++) begin
            if (!ok) break;
            ii = (ii + 1) % 256;
            jj = (jj + int'(s[ii])) % 256;
            t = s[ii]; s[ii] = s[jj]; s[jj] = t;
            p = s[(int'(s[ii]) + int'(s[jj])) % 256] ^ ct_mem[g][n];
            exp_q[g].push_back({n[7:0], p});
            if (chk && (p < 8'h20 || p > 8'h7E)) ok = 1'b0;
        end
        exp_valid_q[g].push_back(ok);
    endtask

    task automatic pulse_en(input int g);
        @(negedge clk); en_v[g] = 1'b1;
        @(negedge clk); en_v[g] = 1'b0;
        check("rdy_low_after_en", rdy_v[g], 0);
    endtask

    task automatic run(input int g, input logic [127:0] kk, input bit spam, input bit mid_chk);
        int w0, r0;
        bit done;
        w0 = wr_cnt[g];
        r0 = rise_cnt[g];
        key_v[g] = kk;
        pulse_en(g);
        key_v[g] = ~kk;                       // key must have been latched at start
        done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if (mid_chk && c == 20) check("valid_cleared_mid_run", valid_v[g], 0);
            en_v[g] = (spam && c < 1500 && (c % 100) == 7);
            if (rdy_v[g]) done = 1'b1;
        end
        en_v[g] = 1'b0;
        if (!done) check("run_timeout", 1, 0);
        repeat (3) @(negedge clk);
        check("pt_writes_pending", exp_q[g].size(), 0);
        check("rdy_rises_once", rise_cnt[g] - r0, 1);
        last_writes = wr_cnt[g] - w0;
    endtask

    initial begin
        byte_q_t ct_key, pt_key, ct_wiki, pt_wiki, ct_empty;
        ct_key   = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        pt_key   = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        ct_wiki  = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
        pt_wiki  = '{8'h05, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
        ct_empty = '{8'h00};
        for (int g = 0; g < 3; g++) key_v[g] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset_rdy[%0d]", g), rdy_v[g], 1);
            check($sformatf("reset_valid[%0d]", g), valid_v[g], 0);
            check($sformatf("reset_wren[%0d]", g), {s_wren_v[g], pt_wren_v[g]}, 0);
            check($sformatf("reset_addr[%0d]", g), {s_addr_v[g], ct_addr_v[g], pt_addr_v[g]}, 0);
        end
        rst_n = 1'b1;

        // "Key" / "Plaintext", 3-byte key.
        load_ct(0, ct_key);
        push_exp(0, pt_key, 1'b1);
        run(0, 128'h4B6579, 1'b0, 1'b0);
        check("key_run_writes", last_writes, 10);

        // "Wiki" / "pedia", 4-byte key.
        load_ct(1, ct_wiki);
        push_exp(1, pt_wiki, 1'b1);
        run(1, 128'h57696B69, 1'b0, 1'b0);
        check("wiki_run_writes", last_writes, 6);

        // Wrong key with the printable check: early abort.
        rc4_push(0, 128'h000000, 3, 1'b1);
        run(0, 128'h000000, 1'b0, 1'b0);
        check("wrong_key_aborts_early", last_writes < 10, 1);

        // Same wrong key with the check disabled: full message.
        load_ct(2, ct_key);
        rc4_push(2, 128'h000000, 3, 1'b0);
        run(2, 128'h000000, 1'b0, 1'b0);
        check("nocheck_full_writes", last_writes, 10);

        // Empty message, then a normal run that must clear valid while busy.
        load_ct(0, ct_empty);
        push_exp(0, ct_empty, 1'b1);
        run(0, 128'h4B6579, 1'b0, 1'b0);
        check("empty_run_writes", last_writes, 1);
        load_ct(0, ct_key);
        push_exp(0, pt_key, 1'b1);
        run(0, 128'h4B6579, 1'b0, 1'b1);

        // en hammered while busy: no restart, identical output.
        push_exp(0, pt_key, 1'b1);
        run(0, 128'h4B6579, 1'b1, 1'b0);
        check("spam_run_writes", last_writes, 10);

        // Asynchronous reset in the middle of KSA.
        key_v[0] = 128'h4B6579;
        pulse_en(0);
        repeat (400) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_rdy", rdy_v[0], 1);
        check("midrun_reset_valid", valid_v[0], 0);
        check("midrun_reset_wren", {s_wren_v[0], pt_wren_v[0]}, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        push_exp(0, pt_key, 1'b1);
        run(0, 128'h4B6579, 1'b0, 1'b0);
        check("after_reset_writes", last_writes, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
